// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for an async FIFO: admits whole bursts only when
// the FIFO has room for every beat, then streams the owner's beats into wr_en/wr_data.
module fifo_wr_arbiter #(
    parameter  int DATA_W    = 16,
    parameter  int FIFO_D    = 32,
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 8,
    localparam int LEN_W     = $clog2(MAX_BURST + 1),
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int RA_W      = $clog2(FIFO_D) + 1
) (
    input  logic                        wr_clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          data_ack,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [ID_W-1:0]             cur_id,
    output logic                        busy,
    input  logic [RA_W-1:0]             room_avail,
    input  logic                        fifo_full,
    output logic                        wr_en,
    output logic [DATA_W-1:0]           wr_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      cur_id_q, cur_id_d;
    logic [ID_W-1:0]      rr_last_q, rr_last_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   eligible;
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      rr_idx;
    int                   idx_int;
    logic [LEN_W-1:0]     win_len;

    // A zero or oversize length can never be admitted, so it never blocks others.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req[i]
                       && (req_len[i*LEN_W +: LEN_W] != '0)
                       && (int'(req_len[i*LEN_W +: LEN_W]) <= MAX_BURST)
                       && (int'(room_avail) >= int'(req_len[i*LEN_W +: LEN_W]));
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave a value held and infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_idx    = '0;
        idx_int   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_int = int'(rr_last_q) + k;
            if (idx_int >= NUM_REQ) idx_int = idx_int - NUM_REQ;
            rr_idx = ID_W'(idx_int);
            if (!win_found && eligible[rr_idx]) begin
                win_found = 1'b1;
                win_id    = rr_idx;
            end
        end
    end

    assign win_len = req_len[win_id*LEN_W +: LEN_W];

    assign wr_en    = (state_q == ST_BURST) && !fifo_full;
    assign data_ack = wr_en ? gnt_q : '0;
    assign wr_data  = req_data[cur_id_q*DATA_W +: DATA_W];
    assign gnt      = gnt_q;
    assign cur_id   = cur_id_q;
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cur_id_d  = cur_id_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d     = NUM_REQ'(1) << win_id;
                    cur_id_d  = win_id;
                    cnt_d     = win_len;
                    rr_last_d = win_id;
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wr_en) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        gnt_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            // One dead cycle lets room_avail catch up with the burst's writes.
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            cur_id_q  <= '0;
            cnt_q     <= '0;
            rr_last_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cur_id_q  <= cur_id_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: protocol-following requesters, a transaction-level
// arbitration model checked every cycle, directed scenarios, then random traffic.
module tb_fifo_wr_arbiter;

    localparam int DATA_W    = 16;
    localparam int FIFO_D    = 32;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 8;
    localparam int LEN_W     = $clog2(MAX_BURST + 1);
    localparam int ID_W      = $clog2(NUM_REQ);
    localparam int RA_W      = $clog2(FIFO_D) + 1;

    logic                        wr_clk;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*LEN_W-1:0]    req_len;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          data_ack;
    logic [NUM_REQ-1:0]          gnt;
    logic [ID_W-1:0]             cur_id;
    logic                        busy;
    logic [RA_W-1:0]             room_avail;
    logic                        fifo_full;
    logic                        wr_en;
    logic [DATA_W-1:0]           wr_data;

    fifo_wr_arbiter #(
        .DATA_W(DATA_W), .FIFO_D(FIFO_D), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)
    ) dut (
        .wr_clk(wr_clk), .rst_n(rst_n), .req(req), .req_len(req_len),
        .req_data(req_data), .data_ack(data_ack), .gnt(gnt), .cur_id(cur_id),
        .busy(busy), .room_avail(room_avail), .fifo_full(fifo_full),
        .wr_en(wr_en), .wr_data(wr_data)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Beat payload tags requester, burst number and beat index so order errors show.
    function automatic logic [DATA_W-1:0] beat_data(input int id, input int bn, input int beat);
        return DATA_W'(((8 + id) << 12) | ((bn & 255) << 4) | (beat & 15));
    endfunction

    // Requester agents and FIFO occupancy.
    int  r_len [NUM_REQ];
    int  r_beat[NUM_REQ];
    int  r_bn  [NUM_REQ];
    bit  r_act [NUM_REQ];
    bit  r_auto[NUM_REQ];
    bit  gen_rand   = 0;
    bit  rnd_mode   = 0;
    bit  full_force = 0;
    int  room_ovr   = FIFO_D;
    int  occ        = 0;
    logic [NUM_REQ-1:0] last_ack = '0;
    bit  last_wr = 0;

    // Reference model state.
    int  m_owner = -1;
    int  m_left, m_done, m_last;
    bit  m_gap;
    int  m_bn[NUM_REQ];
    int  m_idx, m_len;
    logic [NUM_REQ-1:0] e_gnt, e_ack;
    bit  e_wr, e_busy;

    // Observation counters for directed scenarios.
    int  obs_ack [NUM_REQ];
    int  obs_gcyc[NUM_REQ];
    int  obs_wr;
    int  gs_id[$];
    int  gs_cyc[$];
    int  cyc = 0;
    logic [NUM_REQ-1:0] prev_gnt = '0;

    function automatic bit len_invalid(input int l);
        return (l < 1) || (l > MAX_BURST);
    endfunction

    always @(negedge wr_clk) begin
        cyc++;
        if (!rst_n) begin
            check("rst_gnt", gnt, 0);
            check("rst_data_ack", data_ack, 0);
            check("rst_wr_en", wr_en, 0);
            check("rst_busy", busy, 0);
            check("rst_cur_id", cur_id, 0);
            m_owner = -1; m_gap = 0; m_left = 0; m_done = 0; m_last = NUM_REQ - 1;
            for (int i = 0; i < NUM_REQ; i++) m_bn[i] = 0;
            last_ack = '0; last_wr = 0; prev_gnt = '0;
        end else begin
            e_gnt  = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
            e_wr   = (m_owner >= 0) && !fifo_full;
            e_ack  = e_wr ? e_gnt : '0;
            e_busy = (m_owner >= 0) || m_gap;
            check("gnt", gnt, e_gnt);
            check("data_ack", data_ack, e_ack);
            check("wr_en", wr_en, e_wr);
            check("busy", busy, e_busy);
            if (m_owner >= 0) check("cur_id", cur_id, m_owner);
            if (e_wr) check("wr_data", wr_data, beat_data(m_owner, m_bn[m_owner], m_done));

            for (int i = 0; i < NUM_REQ; i++) begin
                obs_ack[i]  += int'(data_ack[i]);
                obs_gcyc[i] += int'(gnt[i]);
            end
            obs_wr += int'(wr_en);
            if (gnt != '0 && prev_gnt == '0) begin
                gs_id.push_back(int'(cur_id));
                gs_cyc.push_back(cyc);
            end
            prev_gnt = gnt;
            last_ack = e_ack;
            last_wr  = e_wr;

            // Advance the model across the coming edge.
            if (m_owner >= 0) begin
                if (e_wr) begin m_done++; m_left--; end
                if (m_left == 0) begin
                    m_bn[m_owner]++;
                    m_owner = -1; m_gap = 1; m_done = 0;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (m_owner < 0) begin
                        m_idx = (m_last + k) % NUM_REQ;
                        m_len = int'(req_len[m_idx*LEN_W +: LEN_W]);
                        if (req[m_idx] && !len_invalid(m_len) && int'(room_avail) >= m_len) begin
                            m_owner = m_idx; m_left = m_len; m_last = m_idx; m_done = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = r_act[i];
            req_len[i*LEN_W +: LEN_W]   = LEN_W'(r_len[i]);
            req_data[i*DATA_W +: DATA_W] = beat_data(i, r_bn[i], r_beat[i]);
        end
        room_avail = RA_W'((room_ovr >= 0) ? room_ovr : (FIFO_D - occ));
        fifo_full  = full_force || (occ >= FIFO_D) || (rnd_mode && $urandom_range(7) == 0);
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
        if (rnd_mode) begin
            occ += int'(last_wr);
            if (occ > 0 && $urandom_range(2) != 0) occ--;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_act[i] && last_ack[i]) begin
                r_beat[i]++;
                if (r_beat[i] == r_len[i]) begin
                    r_beat[i] = 0; r_bn[i]++; r_act[i] = r_auto[i];
                end
            end else if (gen_rand && r_act[i] && len_invalid(r_len[i]) && $urandom_range(7) == 0) begin
                r_act[i] = 0;
            end
            if (gen_rand && !r_act[i] && $urandom_range(3) == 0) begin
                r_act[i]  = 1;
                r_beat[i] = 0;
                if ($urandom_range(9) == 0)
                    r_len[i] = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(MAX_BURST + 1, 15));
                else
                    r_len[i] = int'($urandom_range(1, MAX_BURST));
            end
        end
        drive();
        #1;
    endtask

    task automatic reset_agents();
        for (int i = 0; i < NUM_REQ; i++) begin
            r_act[i] = 0; r_beat[i] = 0; r_bn[i] = 0; r_auto[i] = 0; r_len[i] = 0;
        end
        drive();
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NUM_REQ; i++) begin obs_ack[i] = 0; obs_gcyc[i] = 0; end
        obs_wr = 0;
        gs_id.delete();
        gs_cyc.delete();
    endtask

    task automatic start(input int id, input int len, input bit auto_on);
        r_act[id] = 1; r_len[id] = len; r_beat[id] = 0; r_auto[id] = auto_on;
        drive();
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0;
        reset_agents();
        clear_obs();
        repeat (2) @(posedge wr_clk);
        #2 rst_n = 1'b1;

        // Single len-4 burst: latency, data order, GAP then IDLE.
        clear_obs();
        start(0, 4, 0);
        step();
        check("t1_gnt_first", gnt, 4'b0001);
        check("t1_wr_en_first", wr_en, 1);
        check("t1_data_beat0", wr_data, 16'h8000);
        step();
        check("t1_data_beat1", wr_data, 16'h8001);
        step(); step(); step();
        check("t1_gap_busy", busy, 1);
        check("t1_gap_gnt", gnt, 0);
        step();
        check("t1_idle_busy", busy, 0);
        check("t1_writes", obs_wr, 4);
        check("t1_acks", obs_ack[0], 4);

        // fifo_full stall in the middle of a burst.
        clear_obs();
        start(2, 4, 0);
        step(); step();
        full_force = 1;
        for (int s = 0; s < 3; s++) begin
            step();
            check("t4_stall_wr_en", wr_en, 0);
            check("t4_stall_ack", data_ack, 0);
        end
        full_force = 0;
        repeat (5) step();
        check("t4_writes", obs_wr, 4);
        check("t4_acks", obs_ack[2], 4);

        // Insufficient room holds off admission until room covers the burst.
        clear_obs();
        room_ovr = 3;
        start(1, 4, 0);
        repeat (10) step();
        check("t3_no_grant", obs_gcyc[1], 0);
        room_ovr = 4;
        drive();
        step();
        check("t3_grant", gnt, 4'b0010);
        repeat (6) step();
        check("t3_acks", obs_ack[1], 4);
        room_ovr = FIFO_D;
        drive();

        // Illegal lengths are skipped without blocking a legal request.
        clear_obs();
        start(0, 0, 0);
        start(1, 9, 0);
        start(2, 3, 0);
        repeat (10) step();
        check("t6_ack0", obs_ack[0], 0);
        check("t6_ack1", obs_ack[1], 0);
        check("t6_ack2", obs_ack[2], 3);
        check("t6_gnt0", obs_gcyc[0], 0);
        check("t6_gnt1", obs_gcyc[1], 0);
        r_act[0] = 0; r_act[1] = 0;
        drive();
        step();

        // Reset after two beats: outputs drop without a clock edge, priority restarts.
        start(0, 4, 0);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt", gnt, 0);
        check("t5_async_wr_en", wr_en, 0);
        check("t5_async_busy", busy, 0);
        reset_agents();
        step(); step();
        rst_n = 1'b1;
        start(1, 2, 0);
        start(0, 2, 0);
        step();
        check("t5_post_gnt", gnt, 4'b0001);
        repeat (12) step();

        // All requesters continuously requesting len 2: fair rotation, period 4.
        rst_n = 1'b0;
        reset_agents();
        step(); step();
        rst_n = 1'b1;
        clear_obs();
        for (int i = 0; i < NUM_REQ; i++) start(i, 2, 1);
        repeat (24) step();
        check("t2_grant_count", gs_id.size() >= 5, 1);
        for (int k = 0; k < 5; k++) begin
            if (k < gs_id.size()) check("t2_order", gs_id[k], exp_order[k]);
            if (k > 0 && k < gs_cyc.size()) check("t2_period", gs_cyc[k] - gs_cyc[k-1], 4);
        end
        for (int i = 0; i < NUM_REQ; i++) r_auto[i] = 0;
        repeat (24) step();

        // Random traffic against the model with a live FIFO occupancy.
        rnd_mode = 1; room_ovr = -1; occ = 0; gen_rand = 1;
        repeat (3000) step();
        gen_rand = 0;
        for (int i = 0; i < NUM_REQ; i++) if (len_invalid(r_len[i])) r_act[i] = 0;
        drive();
        repeat (300) step();
        check("rnd_drained", {busy, req}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of the async FIFO among NUM_REQ burst requesters in the write-clock domain. It grants one requester at a time, round-robin. A burst is admitted only when room_avail shows space for the whole burst, so a granted burst never needs to be split. It then sequences the beats into wr_en/wr_data and acknowledges each beat back to the owner.

Parameters:
DATA_W, 16, FIFO write data width; matches the FIFO instance.
FIFO_D, 32, FIFO depth; sets the room_avail width to $clog2(FIFO_D)+1.
NUM_REQ, 4, number of requesters; must be at least 2.
MAX_BURST, 8, largest legal burst length in beats; 1 <= MAX_BURST <= FIFO_D.
(Derived: LEN_W = $clog2(MAX_BURST+1); ID_W = $clog2(NUM_REQ).)

Ports:
wr_clk  in  1  FIFO write-domain clock.
rst_n  in  1  asynchronous active-low reset.
req  in  NUM_REQ  per-requester burst request, level.
req_len  in  NUM_REQ*LEN_W  burst length of requester i, in slice [i*LEN_W +: LEN_W].
req_data  in  NUM_REQ*DATA_W  current beat data of requester i.
data_ack  out  NUM_REQ  one-hot pulse: the beat of requester i was written this cycle.
gnt  out  NUM_REQ  one-hot grant, held for the whole burst.
cur_id  out  ID_W  index of the granted requester.
busy  out  1  high in BURST and GAP.
room_avail  in  $clog2(FIFO_D)+1  free entries, from the FIFO write side.
fifo_full  in  1  FIFO full flag.
wr_en  out  1  FIFO write enable.
wr_data  out  DATA_W  FIFO write data.

Behaviour:
- Reset (async assert, sync release): state IDLE; gnt, data_ack, wr_en and busy are 0; cur_id = 0; beat counter = 0; rr_last = NUM_REQ-1, so requester 0 has first priority.
- Eligibility, requester i: req[i]=1, 1 <= len_i <= MAX_BURST, and room_avail >= len_i.
  - len 0 or len > MAX_BURST: never eligible; other requesters proceed normally.
- IDLE:
  - Combinational round-robin search over eligible requesters, starting at rr_last+1 and wrapping modulo NUM_REQ.
  - On a winner w, at the clock edge: gnt <= onehot(w), cur_id <= w, cnt <= len_w, rr_last <= w, state -> BURST.
  - No eligible requester: stay in IDLE; rr_last unchanged.
- BURST:
  - wr_en = !fifo_full; wr_data = req_data[cur_id] (combinational mux); data_ack[cur_id] = wr_en.
  - Each beat with wr_en=1 decrements cnt.
  - When a beat is written with cnt==1, state -> GAP.
  - fifo_full=1 stalls: no write, no ack, cnt holds.
- GAP: one cycle, gnt=0, wr_en=0, then IDLE. This lets room_avail reflect the burst's writes before the next admission.
  - Requirement on the FIFO side: room_avail reflects every wr_en pulse by the following cycle.
- Latency:
  - Eligible request sampled at edge N: first wr_en in cycle N+1.
  - A burst of L beats without stalls: L write cycles, then GAP, then IDLE. Best-case burst period is L+2 cycles.
- Requester protocol:
  - Hold req and req_len stable from assertion until the first data_ack.
  - Present the next beat on req_data in the cycle after each data_ack.
  - Drop req after the final ack. If req is still high in IDLE, it is treated as a new burst.
- req falling mid-burst is ignored: the burst completes to its admitted length.
- room_avail changes mid-burst are ignored. Only fifo_full gates individual beats.
- Reset mid-burst: all outputs drop immediately. Beats already written remain in the FIFO; unsent beats are discarded.
- Invariants:
  - gnt and data_ack are one-hot or zero.
  - data_ack is never high without wr_en.
  - wr_en is only high in BURST.

Test Plan:
1. req[0]=1, len 4, room 32: gnt[0] from cycle N+1; wr_en high for 4 cycles; wr_data = D0..D3 in order; 4 data_ack[0] pulses; then GAP and IDLE.
2. All 4 requesters, len 2, held continuously: grant order 0,1,2,3,0; each burst is 2 writes then 1 GAP cycle, then 1 IDLE cycle.
3. room_avail=3, req[1] len 4: no grant for 10 cycles. Raise room_avail to 4: gnt[1] the next cycle and 4 writes.
4. len 4 burst with fifo_full=1 during beat 2 for 3 cycles: wr_en and ack low for those 3 cycles, cnt held; exactly 4 writes in total, data order intact.
5. rst_n low after beat 2 of 4: gnt, wr_en and busy are 0 with no clock edge. After release, requester 0 has priority again and an eligible request is granted normally.
6. req[0] len 0, req[1] len 9, req[2] len 3: only requester 2 is granted; requesters 0 and 1 are never granted or acked.
